// File: rtl/sequence_checker_pkg.sv
// ----------------------------------------------------------------------------
// sequence_checker_pkg
//   Shared definitions for the sequence checker and anything that decodes its
//   state (display / debug logic).
//   Contents:
//     ADDR_W_DEF, DATA_W_DEF : default ROM address / data widths
//     state_t                : FSM state encoding (S_IDLE .. S_WIN)
// ----------------------------------------------------------------------------
package sequence_checker_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    // Encodings are visible on state_dbg, so they are fixed explicitly.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_PLAY = 3'd2,
        S_COMPARE   = 3'd3,
        S_LOSE      = 3'd4,
        S_WIN       = 3'd5
    } state_t;

endpackage

// File: rtl/sequence_checker_press_edge_detector.sv
// ----------------------------------------------------------------------------
// press_edge_detector
//   Turns the level-sensitive button vector into single press events. A press
//   is recognised only when some button is down and every button was up on
//   the previous cycle, so a held button yields exactly one press and a new
//   press needs a full release first.
//   Ports:
//     clock        : system clock
//     reset        : synchronous active-high reset (clears history)
//     buttons      : synchronised, active-high button vector
//     new_press    : high for the cycle in which a fresh press is seen
//     press_value  : button vector to latch when new_press is high
// ----------------------------------------------------------------------------
module press_edge_detector #(
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] buttons,
    output logic              new_press,
    output logic [DATA_W-1:0] press_value
);

    logic [DATA_W-1:0] prev_q;

    // History is captured every cycle regardless of the controller's state.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= buttons;
        end
    end

    assign new_press   = (buttons != '0) && (prev_q == '0);
    assign press_value = buttons;

endmodule

// File: rtl/sequence_checker.sv
// ----------------------------------------------------------------------------
// sequence_checker
//   Round controller in front of the LED-pattern sequence ROM. Walks the ROM
//   address, waits for a player press, compares it bit-exact against the
//   one-hot pattern returned by the ROM and reports hit / miss / win.
//   Ports:
//     clock, reset : clock and synchronous active-high reset
//     start        : begin / restart a game (honoured in IDLE, WIN, LOSE)
//     buttons      : synchronised active-high player buttons
//     mem_address  : registered ROM address
//     mem_data     : ROM registered output, valid one clock after address
//     match_count  : correct presses this game (0 .. LAST_ADDR+1)
//     waiting      : high while waiting for a press
//     hit          : one-cycle pulse in the COMPARE cycle of a correct press
//     miss         : high while in LOSE
//     done         : high while in WIN
//     state_dbg    : current state encoding
// ----------------------------------------------------------------------------
module sequence_checker
    import sequence_checker_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LAST_ADDR = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] buttons,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W:0]   match_count,
    output logic              waiting,
    output logic              hit,
    output logic              miss,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    logic              new_press;
    logic [DATA_W-1:0] press_value;

    press_edge_detector #(
        .DATA_W (DATA_W)
    ) u_press (
        .clock       (clock),
        .reset       (reset),
        .buttons     (buttons),
        .new_press   (new_press),
        .press_value (press_value)
    );

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] press_q, press_d;
    logic              hit_d;
    logic              hit_q, miss_q, done_q, waiting_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        press_d = press_q;
        hit_d   = 1'b0;
        case (state_q)
            S_IDLE, S_LOSE, S_WIN: begin
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            // One dead cycle so the ROM output catches up with the address.
            S_FETCH: begin
                state_d = S_WAIT_PLAY;
            end
            S_WAIT_PLAY: begin
                if (new_press) begin
                    press_d = press_value;
                    state_d = S_COMPARE;
                    // mem_data is stable from WAIT_PLAY through COMPARE, so
                    // the result can be registered ahead to land in COMPARE.
                    hit_d   = (press_value == mem_data);
                end
            end
            S_COMPARE: begin
                if (press_q == mem_data) begin
                    count_d = count_q + 1'b1;
                    // Win is decided before incrementing, so no wrap.
                    if (addr_q == LAST) begin
                        state_d = S_WIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_LOSE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            press_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            done_q    <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            press_q   <= press_d;
            hit_q     <= hit_d;
            miss_q    <= (state_d == S_LOSE);
            done_q    <= (state_d == S_WIN);
            waiting_q <= (state_d == S_WAIT_PLAY);
        end
    end

    assign mem_address = addr_q;
    assign match_count = count_q;
    assign waiting     = waiting_q;
    assign hit         = hit_q;
    assign miss        = miss_q;
    assign done        = done_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
// ----------------------------------------------------------------------------
// tb_sequence_checker
//   Directed bench for sequence_checker with a registered ROM model.
// ----------------------------------------------------------------------------
module tb_sequence_checker;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] buttons;
    logic [3:0] mem_address;
    logic [3:0] mem_data;
    logic [4:0] match_count;
    logic       waiting;
    logic       hit;
    logic       miss;
    logic       done;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int hit_cnt = 0;

    logic [3:0] rom [16];

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic       exp_hit;
        int         exp_state;
        int         exp_count;
        int         exp_addr;
    } vec_t;

    vec_t game [16];

    sequence_checker #(
        .ADDR_W    (4),
        .DATA_W    (4),
        .LAST_ADDR (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .buttons     (buttons),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .match_count (match_count),
        .waiting     (waiting),
        .hit         (hit),
        .miss        (miss),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // registered sequence ROM
    always @(posedge clock) mem_data <= rom[mem_address];

    // count hit pulses, sampled at the edge that ends each cycle
    always @(posedge clock) if (hit === 1'b1) hit_cnt <= hit_cnt + 1;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Wait (bounded) for WAIT_PLAY, press, check COMPARE cycle, release,
    // then check the settled state.
    task automatic do_press(input vec_t v, input string tag);
        int n;
        int h0;
        n = 0;
        while (waiting !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (waiting !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s wait_timeout: waiting=%b state=%0d", tag, waiting, state_dbg);
        end
        h0 = hit_cnt;
        buttons = v.btn;
        @(negedge clock);
        check({tag, " compare_state"}, int'(state_dbg), 3);
        check({tag, " hit_pulse"}, int'(hit), int'(v.exp_hit));
        repeat (v.hold - 1) @(negedge clock);
        buttons = 4'b0000;
        repeat (2) @(negedge clock);
        check({tag, " hit_count"}, hit_cnt - h0, int'(v.exp_hit));
        check({tag, " state"}, int'(state_dbg), v.exp_state);
        check({tag, " match_count"}, int'(match_count), v.exp_count);
        check({tag, " mem_address"}, int'(mem_address), v.exp_addr);
    endtask

    initial begin
        vec_t v;
        logic [3:0] pat [16] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8, 4'd8,
                                 4'd4, 4'd2, 4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd4};
        for (int i = 0; i < 16; i++) rom[i] = pat[i];

        // full-game table: every step correct, last one wins
        for (int i = 0; i < 16; i++) begin
            game[i].btn       = pat[i];
            game[i].hold      = 3;
            game[i].exp_hit   = 1'b1;
            game[i].exp_state = (i == 15) ? 5 : 2;
            game[i].exp_count = i + 1;
            game[i].exp_addr  = (i == 15) ? 15 : i + 1;
        end

        start   = 1'b0;
        buttons = 4'b0000;
        do_reset();

        // reset state
        check("rst state", int'(state_dbg), 0);
        check("rst addr", int'(mem_address), 0);
        check("rst count", int'(match_count), 0);
        check("rst flags", int'({hit, miss, done, waiting}), 0);

        // full correct game
        start_game();
        check("start fetch", int'(state_dbg), 1);
        for (int i = 0; i < 16; i++) begin
            do_press(game[i], $sformatf("game%0d", i));
        end
        check("win done", int'(done), 1);
        check("win miss", int'(miss), 0);
        check("win waiting", int'(waiting), 0);
        // start in WIN restarts the game
        start_game();
        check("win restart state", int'(state_dbg), 1);
        check("win restart count", int'(match_count), 0);
        check("win restart done", int'(done), 0);

        // wrong press at step 2
        do_reset();
        start_game();
        v = '{btn: 4'd1, hold: 3, exp_hit: 1'b1, exp_state: 2, exp_count: 1, exp_addr: 1};
        do_press(v, "wrong s0");
        v = '{btn: 4'd1, hold: 3, exp_hit: 1'b1, exp_state: 2, exp_count: 2, exp_addr: 2};
        do_press(v, "wrong s1");
        v = '{btn: 4'd4, hold: 3, exp_hit: 1'b0, exp_state: 4, exp_count: 2, exp_addr: 2};
        do_press(v, "wrong s2");
        check("wrong miss", int'(miss), 1);
        check("wrong done", int'(done), 0);
        // start is ignored-free in LOSE: presses do nothing
        buttons = 4'd2;
        repeat (3) @(negedge clock);
        buttons = 4'd0;
        @(negedge clock);
        check("lose frozen state", int'(state_dbg), 4);
        check("lose frozen count", int'(match_count), 2);

        // restart from LOSE
        start_game();
        check("restart state", int'(state_dbg), 1);
        check("restart addr", int'(mem_address), 0);
        check("restart count", int'(match_count), 0);
        check("restart miss", int'(miss), 0);
        v = '{btn: 4'd1, hold: 3, exp_hit: 1'b1, exp_state: 2, exp_count: 1, exp_addr: 1};
        do_press(v, "restart s0");

        // held button: one press only, then a second press after release
        do_reset();
        start_game();
        v = '{btn: 4'd1, hold: 10, exp_hit: 1'b1, exp_state: 2, exp_count: 1, exp_addr: 1};
        do_press(v, "held s0");
        v = '{btn: 4'd1, hold: 3, exp_hit: 1'b1, exp_state: 2, exp_count: 2, exp_addr: 2};
        do_press(v, "held s1");

        // two buttons at once
        do_reset();
        start_game();
        v = '{btn: 4'd3, hold: 3, exp_hit: 1'b0, exp_state: 4, exp_count: 0, exp_addr: 0};
        do_press(v, "two btn");
        check("two btn miss", int'(miss), 1);

        // reset mid-game at address 5
        do_reset();
        start_game();
        for (int i = 0; i < 5; i++) do_press(game[i], $sformatf("mid%0d", i));
        check("mid addr5", int'(mem_address), 5);
        reset = 1'b1;
        @(negedge clock);
        check("mid rst state", int'(state_dbg), 0);
        check("mid rst addr", int'(mem_address), 0);
        check("mid rst count", int'(match_count), 0);
        check("mid rst flags", int'({hit, miss, done, waiting}), 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle hold", int'(state_dbg), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
